merge_fifo: RTL and testbench
=============================

Name: merge_fifo

Overview:
- Buffer stage directly downstream of busmerge.
- Captures the 112-bit merged word q = {da[47:0], db[63:0]} on a write strobe and holds it in a small synchronous FIFO.
- Presents stored words to the consumer through a registered read port.
- Decouples the combinational merge from the downstream packet/register logic and reports occupancy and error events.

Parameters:
- DATA_WIDTH, 112, word width; equals busmerge output width (48 + 64).
- ADDR_WIDTH, 3, pointer width; depth = 2**ADDR_WIDTH = 8 words.
- AFULL_LEVEL, 6, count at or above which almost_full asserts.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  DATA_WIDTH  merged word from busmerge q; bits [111:64] = da, [63:0] = db.
- wr_en  input  1  write strobe; one word per cycle.
- rd_en  input  1  read strobe; one word per cycle.
- dout  output  DATA_WIDTH  read data, registered.
- dout_valid  output  1  high for one cycle when dout carries a word popped by the previous cycle's rd_en.
- full  output  1  count == 2**ADDR_WIDTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_LEVEL.
- count  output  ADDR_WIDTH+1  words currently stored.
- overflow  output  1  one-cycle pulse when a write is dropped.
- underflow  output  1  one-cycle pulse when a read is refused.
- drop_cnt  output  16  saturating count of dropped writes.

Behaviour:
- Reset (rst high at a clock edge):
  - wr_ptr, rd_ptr, count, drop_cnt all go to 0.
  - dout goes to 0; dout_valid, overflow and underflow go to 0.
  - empty = 1, full = 0, almost_full = 0.
  - Memory contents are not cleared.
  - Reset overrides wr_en and rd_en in the same cycle.
  - Reset mid-stream discards all stored words.
- Write acceptance: write is accepted iff wr_en && (!full || rd_en_accepted).
  - On accept: mem[wr_ptr] <= din, and wr_ptr increments modulo depth (natural wrap of the ADDR_WIDTH-bit pointer).
- Read acceptance: read is accepted iff rd_en && !empty.
  - On accept: dout <= mem[rd_ptr], dout_valid <= 1 on the next cycle, and rd_ptr increments modulo depth.
  - With no accepted read: dout holds its last value and dout_valid <= 0.
- Read latency: 1 cycle from the rd_en edge to dout/dout_valid.
- Write-to-read latency: a word written at edge N can be read at edge N+1 and appears on dout after edge N+1.
- Simultaneous wr_en and rd_en:
  - Not empty, not full: both accepted; count unchanged.
  - Full: read accepted, and the write is accepted into the freed slot; count stays at depth; no overflow.
  - Empty: write accepted, read refused; underflow pulses; count becomes 1; no bypass to dout.
- Dropped write (wr_en && full && !rd_en): no state change except overflow pulses for 1 cycle and drop_cnt increments.
  - drop_cnt saturates at 16'hFFFF.
- Refused read (rd_en && empty): underflow pulses for 1 cycle; pointers, count and dout are unchanged.
- count update: +1 on write-only accept, -1 on read-only accept, unchanged otherwise. It never exceeds depth or goes below 0.
- Flags full, empty and almost_full are combinational decodes of the registered count, so they are glitch-free relative to clk.
- Data ordering: strict FIFO; bit positions of din are preserved exactly in dout (no reordering of the da/db fields).

Decomposition:
- Shared package/header constants:
  - MERGE_DA_WIDTH = 48
  - MERGE_DB_WIDTH = 64
  - MERGE_WIDTH = MERGE_DA_WIDTH + MERGE_DB_WIDTH
  - The default FIFO depth constant.
- busmerge and merge_fifo both use MERGE_WIDTH.
- One sub-module: merge_fifo_mem.
  - Simple dual-port RAM: one synchronous write port and one synchronous read port, DATA_WIDTH x 2**ADDR_WIDTH, inferable as block or distributed RAM.
  - Pointers, count, flags and the error logic stay in merge_fifo.

Test Plan:
- Reset then idle: rst high 2 cycles -> count=0, empty=1, full=0, dout=0, dout_valid=0, drop_cnt=0.
- Single word: write din={48'hFFFFFFFFFFFF, 64'h0}, then rd_en next cycle -> dout=112'hFFFFFFFFFFFF_0000000000000000 with dout_valid=1 one cycle after rd_en; empty=1 afterwards.
- Fill and order:
  - Write 8 words {48'h1..8, 64'hA..} back to back -> full=1, count=8; almost_full asserts when count reaches 6.
  - Read 8 words -> same order, including the {48'h0, 64'hFFFFFFFFFFFFFFFF} pattern intact; the wrap past index 7 is verified by a second fill.
- Overflow: with full, pulse wr_en 3 cycles without rd_en -> overflow high on each of the 3 cycles, drop_cnt=3, stored data unchanged.
- Simultaneous ops:
  - With full, wr_en+rd_en together -> count stays 8, no overflow, new word read last.
  - With empty, wr_en+rd_en -> underflow=1, count=1, dout_valid=0.
- Reset mid-operation: with count=5, assert rst during a wr_en+rd_en cycle -> next cycle count=0, empty=1, dout_valid=0, overflow=0, underflow=0.

Source files
------------

// File: rtl/merge_fifo_pkg.sv
// merge_fifo_pkg: shared widths, depth defaults and the merged-word layout
// used by busmerge and merge_fifo.
// Latency: n/a (constants, types and helper functions only).
// Backpressure: n/a.
package merge_fifo_pkg;

  // Field widths of the busmerge output q = {da, db}.
  localparam int MERGE_DA_WIDTH = 48;
  localparam int MERGE_DB_WIDTH = 64;
  localparam int MERGE_WIDTH    = MERGE_DA_WIDTH + MERGE_DB_WIDTH;

  // Default buffer geometry: 2**3 = 8 words, almost_full at 6.
  localparam int MERGE_FIFO_ADDR_WIDTH  = 3;
  localparam int MERGE_FIFO_DEPTH       = 1 << MERGE_FIFO_ADDR_WIDTH;
  localparam int MERGE_FIFO_AFULL_LEVEL = 6;

  // Width of the saturating dropped-write counter.
  localparam int DROP_CNT_WIDTH = 16;

  // Packed view of a merged word. da sits in the upper bits, so a plain
  // cast between this struct and a MERGE_WIDTH vector keeps bit positions.
  typedef struct packed {
    logic [MERGE_DA_WIDTH-1:0] da;
    logic [MERGE_DB_WIDTH-1:0] db;
  } merge_word_t;

  // Increment that holds at all-ones instead of wrapping to zero.
  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(
    input logic [DROP_CNT_WIDTH-1:0] v
  );
    if (&v) begin
      return v;
    end
    return v + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/merge_fifo_mem.sv
// merge_fifo_mem: simple dual-port RAM, DATA_WIDTH x 2**ADDR_WIDTH, with one
// synchronous write port and one synchronous (registered) read port.
// Latency: read data appears one cycle after rd_en_i; no backpressure.
// Ports:
//   clk, rst         - clock and synchronous active-high reset (read register only)
//   wr_en_i/addr/data - write port; stores wr_data_i at wr_addr_i on the edge
//   rd_en_i/addr      - read port; rd_data_o loads mem[rd_addr_i] on the edge
//   rd_data_o         - registered read data; holds when rd_en_i is low
module merge_fifo_mem
  import merge_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = MERGE_WIDTH,
  parameter int ADDR_WIDTH = MERGE_FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Storage array is deliberately never reset so it maps onto RAM primitives.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read-before-write: when a full FIFO reads and writes the same slot in one
  // cycle, the read returns the old word, which is the one being popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/merge_fifo.sv
// merge_fifo: 8-deep buffer for the 112-bit busmerge word {da, db}, with
// occupancy flags, overflow/underflow pulses and a saturating drop counter.
// Latency: read data one cycle after rd_en; a word written at edge N is
// readable at edge N+1. Backpressure: writes to a full FIFO are dropped
// (overflow pulse, drop_cnt++) unless a read frees a slot in the same cycle;
// reads of an empty FIFO are refused (underflow pulse).
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   din, wr_en           - write word and strobe
//   rd_en                - read strobe
//   dout, dout_valid     - registered read data and its one-cycle valid
//   full, empty, almost_full, count - occupancy (decoded from registered count)
//   overflow, underflow  - registered one-cycle error pulses
//   drop_cnt             - saturating count of dropped writes
module merge_fifo
  import merge_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = MERGE_WIDTH,
  parameter int ADDR_WIDTH  = MERGE_FIFO_ADDR_WIDTH,
  parameter int AFULL_LEVEL = MERGE_FIFO_AFULL_LEVEL
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     din,
  input  logic                      wr_en,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      dout_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic [ADDR_WIDTH:0]       count,
  output logic                      overflow,
  output logic                      underflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  // Registered state and next-state.
  logic [ADDR_WIDTH-1:0]     wr_ptr_q,     wr_ptr_d;
  logic [ADDR_WIDTH-1:0]     rd_ptr_q,     rd_ptr_d;
  logic [ADDR_WIDTH:0]       count_q,      count_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q,   drop_cnt_d;
  logic                      dout_valid_q, dout_valid_d;
  logic                      overflow_q,   overflow_d;
  logic                      underflow_q,  underflow_d;

  // Handshake decode for this cycle.
  logic rd_acc;
  logic wr_acc;
  logic wr_drop;
  logic rd_refuse;

  // Flags come straight off the registered count, so they never glitch
  // with respect to clk.
  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_CNT);
  assign almost_full = (count_q >= AFULL_CNT);

  // A full FIFO still takes a write when a read frees a slot in the same
  // cycle; an empty FIFO never bypasses the incoming word to dout.
  assign rd_acc    = rd_en && !empty;
  assign wr_acc    = wr_en && (!full || rd_acc);
  assign wr_drop   = wr_en && !wr_acc;
  assign rd_refuse = rd_en && empty;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    drop_cnt_d   = drop_cnt_q;
    dout_valid_d = rd_acc;
    overflow_d   = wr_drop;
    underflow_d  = rd_refuse;

    // Pointers wrap naturally at 2**ADDR_WIDTH.
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (wr_drop) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_cnt_q   <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_cnt_q   <= drop_cnt_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Reset must also block RAM writes so it overrides a same-cycle wr_en.
  merge_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_acc && !rst),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (din),
    .rd_en_i   (rd_acc && !rst),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (dout)
  );

  assign count      = count_q;
  assign drop_cnt   = drop_cnt_q;
  assign dout_valid = dout_valid_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_merge_fifo.sv
module tb_merge_fifo;

  logic         clk;
  logic         rst;
  logic [111:0] din;
  logic         wr_en;
  logic         rd_en;
  logic [111:0] dout;
  logic         dout_valid;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic [3:0]   count;
  logic         overflow;
  logic         underflow;
  logic [15:0]  drop_cnt;

  merge_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: contents as a plain queue, plus expected side outputs.
  logic [111:0] mq[$];
  logic [111:0] sb[$];        // expected read data, in pop order
  logic [111:0] m_dout;
  logic [15:0]  m_drop;
  logic         e_vld, e_ovf, e_unf;

  task automatic chk(input string nm, input logic [111:0] act, input logic [111:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [111:0] rand_word();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[111:0];
  endfunction

  // One clock cycle: drive inputs, advance the model, check status after the edge.
  task automatic step(input logic r_s, input logic w, input logic r, input logic [111:0] d);
    bit ra, wa;
    rst = r_s; wr_en = w; rd_en = r; din = d;
    if (r_s) begin
      mq.delete();
      m_drop = 16'h0;
      m_dout = '0;
      e_vld = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
    end else begin
      ra = r && (mq.size() > 0);
      wa = w && ((mq.size() < 8) || ra);
      e_vld = ra;
      e_ovf = w && !wa;
      e_unf = r && (mq.size() == 0);
      if (ra) begin
        m_dout = mq.pop_front();
        sb.push_back(m_dout);
      end
      if (wa) mq.push_back(d);
      if (e_ovf && m_drop != 16'hFFFF) m_drop = m_drop + 16'h1;
    end
    @(posedge clk);
    #1;
    chk("count",       112'(count),       112'(mq.size()));
    chk("empty",       112'(empty),       112'(mq.size() == 0));
    chk("full",        112'(full),        112'(mq.size() == 8));
    chk("almost_full", 112'(almost_full), 112'(mq.size() >= 6));
    chk("dout_valid",  112'(dout_valid),  112'(e_vld));
    chk("overflow",    112'(overflow),    112'(e_ovf));
    chk("underflow",   112'(underflow),   112'(e_unf));
    chk("drop_cnt",    112'(drop_cnt),    112'(m_drop));
    if (!e_vld) chk("dout_hold", dout, m_dout);
  endtask

  // Scoreboard monitor: every presented word must match the next expected one.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL dout_unexpected: got %0h expected no word", dout);
      end else begin
        chk("dout_data", dout, sb.pop_front());
      end
    end
  end

  initial begin
    logic [111:0] w;
    int wp, rp;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    m_dout = '0; m_drop = '0;

    // Reset then idle.
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    step(0, 0, 0, '0);

    // Single word, read on the next cycle.
    step(0, 1, 0, {48'hFFFF_FFFF_FFFF, 64'h0});
    step(0, 0, 1, '0);
    step(0, 0, 0, '0);

    // Fill with ordered pattern including an all-db-ones word.
    for (int i = 0; i < 8; i++) begin
      if (i == 3) w = {48'h0, 64'hFFFF_FFFF_FFFF_FFFF};
      else        w = {48'(i + 1), 64'hA + 64'(i)};
      step(0, 1, 0, w);
    end

    // Overflow: three dropped writes.
    for (int i = 0; i < 3; i++) step(0, 1, 0, rand_word());

    // Full with simultaneous read+write; new word must come out last.
    step(0, 1, 1, {48'hBEEF, 64'h1234_5678});
    for (int i = 0; i < 8; i++) step(0, 0, 1, '0);
    step(0, 0, 0, '0);

    // Second fill/drain exercises pointer wrap.
    for (int i = 0; i < 8; i++) step(0, 1, 0, rand_word());
    for (int i = 0; i < 8; i++) step(0, 0, 1, '0);

    // Empty with simultaneous read+write: underflow, count 1, no bypass.
    step(0, 1, 1, rand_word());
    step(0, 0, 1, '0);
    step(0, 0, 0, '0);

    // Reset mid-stream with count = 5.
    for (int i = 0; i < 5; i++) step(0, 1, 0, rand_word());
    step(1, 1, 1, rand_word());
    step(0, 0, 0, '0);

    // Randomized traffic in phases biased toward filling, draining, balanced.
    for (int ph = 0; ph < 3; ph++) begin
      wp = (ph == 0) ? 75 : (ph == 1) ? 30 : 55;
      rp = (ph == 0) ? 30 : (ph == 1) ? 75 : 50;
      for (int i = 0; i < 300; i++) begin
        step(($urandom_range(0, 149) == 0),
             ($urandom_range(0, 99) < wp),
             ($urandom_range(0, 99) < rp),
             rand_word());
      end
    end

    // Drain and confirm no expected word was left unseen.
    for (int i = 0; i < 10; i++) step(0, 0, 1, '0);
    step(0, 0, 0, '0);
    @(negedge clk);
    chk("scoreboard_left", 112'(sb.size()), 112'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
